// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM states, legal oversampling
// ratios, parity types and the 2-of-3 majority helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and three-tap majority sampler centred on the bit middle.
// bit_end marks the last oversampling edge of each bit period.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  active,
  input  logic                  rx_s,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit,
  output logic                  bit_end
);

  logic [PRESCALE_W-1:0] edge_cnt_reg;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last_edge;
  logic [2:0]            samples;

  assign half      = prescale >> 1;
  assign last_edge = prescale - PRESCALE_W'(1);
  assign bit_end   = active && (edge_cnt_reg == last_edge);

  // Counter is parked at zero while idle so a new frame always starts aligned.
  always_ff @(posedge clk) begin
    if (rst || !active) begin
      edge_cnt_reg <= '0;
    end else if (bit_end) begin
      edge_cnt_reg <= '0;
    end else begin
      edge_cnt_reg <= edge_cnt_reg + PRESCALE_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tap
      logic [PRESCALE_W-1:0] tap_point;
      logic                  tap_reg;

      assign tap_point = half + PRESCALE_W'(gi) - PRESCALE_W'(1);

      always_ff @(posedge clk) begin
        if (rst) begin
          tap_reg <= 1'b1;
        end else if (active && (edge_cnt_reg == tap_point)) begin
          tap_reg <= rx_s;
        end
      end

      assign samples[gi] = tap_reg;
    end
  endgenerate

  assign sampled_bit = majority3(samples);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx_in, frames start/data/parity/stop bits and
// reports each byte with a one-cycle data_valid, or a par_err/stp_err strobe.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  state_t state_reg, state_next;

  logic                  sync1_reg, rx_s;
  logic [PRESCALE_W-1:0] prescale_reg;
  logic                  par_en_reg, par_typ_reg;
  logic [BIT_CNT_W-1:0]  bit_cnt_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  frame_bad_reg;
  logic [DATA_WIDTH-1:0] p_data_reg;
  logic                  data_valid_reg, par_err_reg, stp_err_reg;

  logic data_valid_next, par_err_next, stp_err_next;
  logic start_det, sampled_bit, bit_end, parity_exp;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      sync1_reg <= rx_in;
      rx_s      <= sync1_reg;
    end
  end

  uart_rx_sampler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .active     (state_reg != IDLE),
    .rx_s       (rx_s),
    .prescale   (prescale_reg),
    .sampled_bit(sampled_bit),
    .bit_end    (bit_end)
  );

  assign start_det  = (state_reg == IDLE) && !rx_s;
  assign parity_exp = (^shift_reg) ^ (par_typ_reg == PAR_ODD);

  always_comb begin
    state_next      = state_reg;
    data_valid_next = 1'b0;
    par_err_next    = 1'b0;
    stp_err_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        // A start bit that does not hold low through its middle is line noise.
        if (bit_end) state_next = sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt_reg == LAST_BIT)) state_next = par_en_reg ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) begin
          state_next   = STOP;
          par_err_next = (sampled_bit != parity_exp);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          if (!sampled_bit) stp_err_next = 1'b1;
          else if (!frame_bad_reg) data_valid_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      prescale_reg   <= PRESCALE_W'(PRESCALE_8);
      par_en_reg     <= 1'b0;
      par_typ_reg    <= PAR_EVEN;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      frame_bad_reg  <= 1'b0;
      p_data_reg     <= '0;
      data_valid_reg <= 1'b0;
      par_err_reg    <= 1'b0;
      stp_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      data_valid_reg <= data_valid_next;
      par_err_reg    <= par_err_next;
      stp_err_reg    <= stp_err_next;

      // Frame configuration is frozen at the start edge for the whole frame.
      if (start_det) begin
        prescale_reg  <= prescale;
        par_en_reg    <= par_en;
        par_typ_reg   <= par_typ;
        frame_bad_reg <= 1'b0;
        bit_cnt_reg   <= '0;
      end

      if ((state_reg == DATA) && bit_end) begin
        shift_reg   <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
        bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
      end

      if (par_err_next) frame_bad_reg <= 1'b1;
      if (data_valid_next) p_data_reg <= shift_reg;
    end
  end

  assign p_data     = p_data_reg;
  assign data_valid = data_valid_reg;
  assign par_err    = par_err_reg;
  assign stp_err    = stp_err_reg;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, the receive side of the serial link, paired with the existing transmitter.
- Oversamples `rx_in`, detects and qualifies the start bit, then majority-samples 8 data bits LSB-first, an optional parity bit and one stop bit.
- Presents the received byte on `p_data` with a one-cycle `data_valid` strobe; flags parity and stop errors.
- Feeds the system controller's receive path.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the `prescale` input and of the internal edge counter.

Ports:
- clk  input  1  system clock, runs at prescale × baud rate
- rst  input  1  synchronous, active-high reset
- rx_in  input  1  serial line, idle high, asynchronous to clk
- prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
- par_en  input  1  1 = parity bit present after the data bits
- par_typ  input  1  0 = even parity, 1 = odd parity
- p_data  output  DATA_WIDTH  last correctly received byte
- data_valid  output  1  one-cycle strobe, `p_data` updated this cycle
- par_err  output  1  one-cycle strobe, parity mismatch
- stp_err  output  1  one-cycle strobe, stop bit sampled low

Behaviour:
- Reset, synchronous, active-high:
  - state = IDLE; edge_cnt, bit_cnt and shift register = 0; synchronizer flops = 1.
  - p_data = 0; data_valid = 0; par_err = 0; stp_err = 0.
  - Reset asserted mid-frame aborts the frame with no strobes.
- Synchronizer: `rx_in` passes through two flops; all decisions use the synchronized value `rx_s`.
- Configuration latch: `prescale`, `par_en` and `par_typ` are latched on start detection and held for the whole frame. Changes mid-frame do not affect that frame.
- Bit timing:
  - edge_cnt counts 0..prescale-1 within each bit period, then wraps to 0 and bit_cnt advances.
  - Samples are taken at edge_cnt = prescale/2-1, prescale/2 and prescale/2+1.
  - The bit value is the 2-of-3 majority, valid from edge_cnt = prescale/2+2.
  - All per-bit decisions are taken at edge_cnt = prescale-1.
- States:
  - IDLE: `rx_s` = 0 → START with edge_cnt = 0; otherwise stay.
  - START: at end of bit, majority = 1 → glitch, go to IDLE with no strobes; majority = 0 → DATA, bit_cnt = 0.
  - DATA: at end of each bit, shift the majority value into the MSB (LSB-first reception). After bit_cnt = DATA_WIDTH-1 → PARITY if par_en, else STOP.
  - PARITY: expected = XOR of the 8 received bits, inverted when par_typ = 1. Mismatch sets an internal frame_bad flag and pulses par_err for one cycle at end of bit. → STOP.
  - STOP, at end of bit:
    - majority = 0 → stp_err pulses one cycle;
    - else if !frame_bad → p_data loads the shift register and data_valid pulses one cycle;
    - → IDLE in all cases.
- Output timing: all strobes are registered and high exactly one cycle, in the cycle after the edge where edge_cnt = prescale-1.
- Error outcome: on a parity or stop error, `p_data` keeps its previous value and `data_valid` stays low.
- Parity and stop both wrong: par_err pulses at end of the parity bit, stp_err at end of the stop bit, and there is no data_valid.
- Back-to-back frames: a start bit directly after the stop bit is caught because IDLE is entered on the last stop-bit edge. No idle gap is required.
- End-to-end latency: 2 synchronizer cycles plus (10 or 11) × prescale cycles from the falling start edge at `rx_in`.
- Illegal `prescale` values: behaviour undefined, not checked.

Decomposition:
- Package uart_rx_pkg holds:
  - the state encoding localparams (IDLE, START, DATA, PARITY, STOP);
  - the legal prescale constants 8, 16 and 32;
  - the parity type constants EVEN = 0 and ODD = 1.
- Sub-module uart_rx_sampler contains the edge counter and 3-sample majority vote. It outputs `sampled_bit` and a `bit_end` pulse; the FSM, shift register, parity check and outputs stay in uart_rx.

Test Plan:
- Normal frame, even parity: prescale = 8, par_en = 1, par_typ = 0, frame 0xA5 with parity 0 → data_valid pulses once, p_data = 0xA5, par_err = stp_err = 0.
- Parity error: prescale = 16, par_en = 1, par_typ = 1, frame 0x3C with parity 0 (correct odd parity is 1) → par_err pulses once, no data_valid, p_data keeps its previous value.
- Framing error: prescale = 8, par_en = 0, byte 0x81 with stop bit driven 0 → stp_err pulses once at end of the stop bit, no data_valid.
- Start glitch and noise rejection, prescale = 8:
  - rx_in low for 3 cycles only → returns to IDLE, no strobes;
  - a 1-cycle spike inside a data bit at a sample point → majority rejects it, byte received correctly.
- Back-to-back frames: prescale = 32, par_en = 0, frames 0x00 then 0xFF with no idle gap → two data_valid pulses, p_data = 0x00 then 0xFF.
- Reset mid-frame: assert rst during data bit 4 of 0x55 → all outputs 0 the next cycle, no strobes; a following 0x12 frame is received correctly.
